// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-ported register file.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int aw_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage mux, write bypass and busy forwarding.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = aw_of(NREG)
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] regs [NREG],
    input  logic [NREG-1:0] busy_vec,
    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [XLEN-1:0] wr0_data,
    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [XLEN-1:0] wr1_data,
    output logic [XLEN-1:0] data,
    output logic            busy
);

    logic hit0;
    logic hit1;
    logic is_zero;

    assign hit0    = (BYPASS != 0) && wr0_en && (wr0_addr == addr);
    assign hit1    = (BYPASS != 0) && wr1_en && (wr1_addr == addr);
    assign is_zero = (ZERO_REG != 0) && (addr == '0);

    always_comb begin
        data = regs[addr];
        busy = busy_vec[addr];
        // write port 1 has priority over port 0
        if (hit1) begin
            data = wr1_data;
            busy = 1'b0;
        end else if (hit0) begin
            data = wr0_data;
            busy = 1'b0;
        end
        if (is_zero) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with two write ports and a busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = aw_of(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs   [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_d;

    always_comb begin
        regs_d = regs;
        busy_d = busy;
        if (wr0_en) begin
            regs_d[wr0_addr] = wr0_data;
            busy_d[wr0_addr] = 1'b0;
        end
        if (wr1_en) begin
            regs_d[wr1_addr] = wr1_data;
            busy_d[wr1_addr] = 1'b0;
        end
        // issue after writes so a same-cycle issue leaves the bit set
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            regs <= regs_d;
            busy <= busy_d;
        end
    end

    assign busy_vec = busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_read_port #(
            .XLEN     (XLEN),
            .NREG     (NREG),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .addr     (rs_addr[k*AW +: AW]),
            .regs     (regs),
            .busy_vec (busy),
            .wr0_en   (wr0_en),
            .wr0_addr (wr0_addr),
            .wr0_data (wr0_data),
            .wr1_en   (wr1_en),
            .wr1_addr (wr1_addr),
            .wr1_data (wr1_data),
            .data     (rs_data[k*XLEN +: XLEN]),
            .busy     (rs_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: bypassing and non-bypassing instances.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [31:0] busy_vec;
    logic [63:0] nb_rs_data;
    logic [1:0]  nb_rs_busy;
    logic [31:0] nb_busy_vec;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (busy_vec)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rs_data  (nb_rs_data),
        .rs_busy  (nb_rs_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (nb_busy_vec)
    );

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    localparam int S_D0  = 0;
    localparam int S_D1  = 1;
    localparam int S_BIT = 2;
    localparam int S_RB0 = 3;
    localparam int S_BV  = 4;
    localparam int S_NB0 = 5;
    localparam int S_RB1 = 6;

    chk_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] actual(input int sel, input int idx);
        case (sel)
            S_D0:    return rs_data[31:0];
            S_D1:    return rs_data[63:32];
            S_BIT:   return {31'b0, busy_vec[idx]};
            S_RB0:   return {31'b0, rs_busy[0]};
            S_BV:    return busy_vec;
            S_NB0:   return nb_rs_data[31:0];
            default: return {31'b0, rs_busy[1]};
        endcase
    endfunction

    // monitor: compares every record scheduled for the current cycle
    always @(negedge clk) begin
        chk_t c;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc == cyc) begin
            c   = q.pop_front();
            act = actual(c.sel, c.idx);
            checks++;
            if (act !== c.exp) begin
                fails++;
                $display("FAIL %s cyc=%0d got=%h expected=%h",
                         c.name, cyc, act, c.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int sel,
                              input int idx, input logic [31:0] v);
        chk_t c;
        c.cyc  = cyc;
        c.name = name;
        c.sel  = sel;
        c.idx  = idx;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        wr0_en   = 1'b1;
        wr0_addr = a;
        wr0_data = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        wr1_en   = 1'b1;
        wr1_addr = a;
        wr1_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        rs_addr  = '0;
        wr0_en   = 1'b0;
        wr0_addr = '0;
        wr0_data = '0;
        wr1_en   = 1'b0;
        wr1_addr = '0;
        wr1_data = '0;
        iss_en   = 1'b0;
        iss_addr = '0;

        // reset held with a write and issue pending
        @(posedge clk);
        #1;
        wr0(5'd4, 32'h1234);
        iss(5'd4);
        @(posedge clk);
        #1;
        rd(5'd4, 5'd6);
        expect_val("rst_busy_vec", S_BV, 0, 32'h0);
        expect_val("rst_nb_data0", S_NB0, 0, 32'h0);
        expect_val("rst_rs_busy0", S_RB0, 0, 32'h0);

        step();
        expect_val("post_rst_busy_vec", S_BV, 0, 32'h0);
        for (int a = 0; a < 32; a++) begin
            step();
            rd(5'(a), 5'(31 - a));
            expect_val("rst_read0", S_D0, 0, 32'h0);
            expect_val("rst_read1", S_D1, 0, 32'h0);
        end

        // write r5 with same-cycle read
        step();
        wr0(5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd5);
        expect_val("bypass_r5", S_D0, 0, 32'hDEADBEEF);
        expect_val("bypass_r5_p1", S_D1, 0, 32'hDEADBEEF);
        expect_val("nobypass_r5_pre", S_NB0, 0, 32'h0);
        step();
        expect_val("r5_after", S_D0, 0, 32'hDEADBEEF);
        expect_val("nobypass_r5_post", S_NB0, 0, 32'hDEADBEEF);

        // dual write to r7: port 1 wins
        step();
        wr0(5'd7, 32'h11);
        wr1(5'd7, 32'h22);
        rd(5'd5, 5'd7);
        expect_val("bypass_prio_r7", S_D1, 0, 32'h22);
        expect_val("r5_hold", S_D0, 0, 32'hDEADBEEF);
        step();
        rd(5'd7, 5'd7);
        expect_val("r7_prio", S_D0, 0, 32'h22);
        expect_val("nobypass_r7", S_NB0, 0, 32'h22);

        // writes and issue to r0 are discarded
        step();
        wr0(5'd0, 32'hFFFFFFFF);
        wr1(5'd0, 32'hFFFFFFFF);
        iss(5'd0);
        rd(5'd0, 5'd0);
        expect_val("r0_bypass", S_D0, 0, 32'h0);
        expect_val("r0_busy_same", S_RB0, 0, 32'h0);
        step();
        expect_val("r0_read", S_D0, 0, 32'h0);
        expect_val("r0_busy", S_BIT, 0, 32'h0);
        expect_val("r0_nb", S_NB0, 0, 32'h0);

        // issue r3, write it two cycles later
        step();
        iss(5'd3);
        rd(5'd3, 5'd3);
        expect_val("r3_busy_pre", S_BIT, 3, 32'h0);
        step();
        expect_val("r3_busy_c1", S_BIT, 3, 32'h1);
        expect_val("r3_rs_busy_c1", S_RB0, 0, 32'h1);
        expect_val("r3_busy_vec_c1", S_BV, 0, 32'h8);
        step();
        wr1(5'd3, 32'h5);
        expect_val("r3_busy_c2", S_BIT, 3, 32'h1);
        expect_val("r3_rs_busy_fwd", S_RB0, 0, 32'h0);
        expect_val("r3_data_fwd", S_D0, 0, 32'h5);
        expect_val("r3_nb_pre", S_NB0, 0, 32'h0);
        step();
        expect_val("r3_busy_clear", S_BIT, 3, 32'h0);
        expect_val("r3_data", S_D0, 0, 32'h5);
        expect_val("r3_nb_data", S_NB0, 0, 32'h5);

        // issue and write r9 together, then reset over a write
        step();
        iss(5'd9);
        wr0(5'd9, 32'hA);
        rd(5'd9, 5'd5);
        step();
        expect_val("r9_busy", S_BIT, 9, 32'h1);
        expect_val("r9_data", S_D0, 0, 32'h0000000A);
        expect_val("r9_rs_busy", S_RB0, 0, 32'h1);
        expect_val("r5_still", S_D1, 0, 32'hDEADBEEF);
        step();
        rst_n = 1'b0;
        wr0(5'd9, 32'hB);
        iss(5'd12);
        expect_val("r9_nb_in_rst", S_NB0, 0, 32'h0000000A);
        step();
        expect_val("r9_after_rst", S_D0, 0, 32'h0);
        expect_val("r9_busy_after_rst", S_BIT, 9, 32'h0);
        expect_val("busy_vec_after_rst", S_BV, 0, 32'h0);
        expect_val("r5_after_rst", S_D1, 0, 32'h0);
        expect_val("rs_busy1_after_rst", S_RB1, 0, 32'h0);

        step();
        step();
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
